bus_bridge: RTL and testbench
=============================

# bus_bridge

CPU-side system bridge that is the initiator end of the peripheral register bus. It decodes processor load/store requests into one-cycle device accesses, returns registered read data with a ready handshake, and aggregates device IRQ lines into the processor's hardware-interrupt vector. It sits between the CPU datapath/CP0 and up to three word-addressed peripherals, such as timers. Each peripheral has four 32-bit registers selected by ADDR[3:2].

## Interface
Parameters:
- DEV0_BASE, 32'h0000_7F00, base byte address of device 0 (16-byte window)
- DEV1_BASE, 32'h0000_7F10, base of device 1
- DEV2_BASE, 32'h0000_7F20, base of device 2
- STAT_BASE, 32'h0000_7F30, base of the bridge's own status window

Ports:
- CLK_I  in  1  sole clock; every register updates on the rising edge
- RST_I  in  1  reset, asynchronous, active-low
- PrReq  in  1  CPU access request; held stable until PrReady
- PrWE  in  1  1 = store, 0 = load; qualified by PrReq
- PrAddr  in  32  byte address; bits [1:0] ignored
- PrWD  in  32  store data
- PrRD  out  32  load data; valid only while PrReady=1
- PrReady  out  1  one-cycle completion pulse
- PrErr  out  1  one-cycle pulse with PrReady when the address is unmapped
- DEV_ADDR  out  2  register select [3:2] to all devices
- DEV_WD  out  32  write data to all devices
- DEV_WE  out  3  per-device write strobe, one-hot or zero
- DEV_RD0, DEV_RD1, DEV_RD2  in  32 each  combinational device read data
- DEV_IRQ  in  3  level interrupt requests from the devices
- HWINT  out  6  interrupt vector to CP0; [2:0] = registered DEV_IRQ, [5:3] = 0

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- **IDLE:** PrReq=1 latches PrWE, PrAddr[31:2] and PrWD, then moves to ACCESS. PrReq=0 stays in IDLE.
- **ACCESS:** the bridge drives DEV_ADDR and DEV_WD from the latched fields.
  - For a mapped store, the matching DEV_WE bit is 1 for exactly this cycle.
  - For a load, the selected DEV_RDn (or the status word) is registered at the end of this cycle.
  - The state then moves to RESP.
- **RESP:** PrReady=1, and PrRD holds the captured data (0 for stores and unmapped loads). The state returns to IDLE.
- PrReq is sampled only in IDLE. If PrReq is still high in the IDLE cycle after RESP, that is a new access.
- **Decode:** hit = (PrAddr[31:4] == BASE[31:4]).
  - No hit gives an unmapped access: no DEV_WE, PrRD=0, and PrErr=1 alongside PrReady.
  - The unmapped access also sets the sticky ERR flag.
- **Status window** (STAT_BASE):
  - word 0 reads {29'b0, raw DEV_IRQ}.
  - word 1 reads {31'b0, ERR}. A store of any value to word 1 clears ERR.
  - Stores to words 0, 2 and 3 are ignored; loads of words 2 and 3 return 0.
- **Simultaneous events:** if an unmapped access completes in the same cycle as an ERR clear, set wins. Only one access is in flight at a time, so this arises only across back-to-back accesses and must still hold.
- **Interrupts:** HWINT[2:0] follows DEV_IRQ through one register stage, with no masking or latching; level semantics are preserved.
- **Reset (RST_I=0), asynchronous:** state=IDLE; PrReady, PrErr and DEV_WE = 0; PrRD, DEV_ADDR, DEV_WD and the latches = 0; ERR=0; HWINT=0.
- Reset asserted mid-access aborts the access immediately. No write strobe may escape after reset is asserted.

## Timing
- An access accepted at edge N has DEV_WE high during cycle N+1. PrReady is high during cycle N+2.
- Load latency is 2 cycles. Maximum throughput is one access per 3 cycles.
- Read data is sampled at the edge ending ACCESS. A device counter updating on that same edge returns its pre-edge value.
- HWINT lags DEV_IRQ by one cycle.
- All outputs are registered except DEV_ADDR and DEV_WD, which are driven directly from the latches (also registered).

## Structure
- Package bridge_pkg holds the state enum (IDLE, ACCESS, RESP), the default base constants, and the device-index constants DEV_TIMER0=0, DEV_TIMER1=1, DEV_GPIO=2, DEV_STAT=3, DEV_NONE=4.
- One sub-module, bridge_decode, is purely combinational: word address in, device index out. It is instantiated once on the latched address.

## Test plan
- **Store then load, device 0:** store 32'h0000_0009 to 32'h7F00, then load 7F00.
  - DEV_WE=3'b001 for one cycle with DEV_ADDR=0.
  - The load returns 32'h0000_0009 with PrReady two cycles after acceptance.
- **Unmapped access:** store to 32'h7F40.
  - DEV_WE stays 0; PrErr and PrReady pulse together.
  - A subsequent load of 7F34 returns 1.
  - A store to 7F34 followed by a load of 7F34 returns 0.
- **Back-to-back:** hold PrReq high across two accesses (load 7F14, store 7F24).
  - Exactly one PrReady per access, three cycles apart.
  - The DEV_WE=3'b100 pulse is one cycle wide.
- **Interrupt:** raise DEV_IRQ=3'b010.
  - HWINT=6'b000010 one cycle later; a load of 7F30 returns 2.
  - Dropping DEV_IRQ clears HWINT one cycle later.
- **Reset during ACCESS:** assert RST_I low mid-cycle during a store to 7F10.
  - DEV_WE and PrReady drop immediately.
  - After release the FSM is in IDLE, and the device register is unchanged if reset came before the edge.
- **Counter sampling:** load 7F08 while the device count changes on the ACCESS edge. PrRD equals the pre-edge count.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and constants for the CPU-side peripheral bus bridge.
// Address decode lives here as a function so the request path and the latched path agree.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [31:0] DEFAULT_DEV0_BASE = 32'h0000_7F00;
    localparam logic [31:0] DEFAULT_DEV1_BASE = 32'h0000_7F10;
    localparam logic [31:0] DEFAULT_DEV2_BASE = 32'h0000_7F20;
    localparam logic [31:0] DEFAULT_STAT_BASE = 32'h0000_7F30;

    localparam logic [2:0] DEV_TIMER0 = 3'd0;
    localparam logic [2:0] DEV_TIMER1 = 3'd1;
    localparam logic [2:0] DEV_GPIO   = 3'd2;
    localparam logic [2:0] DEV_STAT   = 3'd3;
    localparam logic [2:0] DEV_NONE   = 3'd4;

    // Each window is 16 bytes, so only the tag above bit 4 takes part in the match.
    function automatic logic [2:0] decode_tag(
        input logic [27:0] tag,
        input logic [27:0] tag0,
        input logic [27:0] tag1,
        input logic [27:0] tag2,
        input logic [27:0] tag_stat
    );
        logic [2:0] dev;
        dev = DEV_NONE;
        if (tag == tag0) begin
            dev = DEV_TIMER0;
        end else if (tag == tag1) begin
            dev = DEV_TIMER1;
        end else if (tag == tag2) begin
            dev = DEV_GPIO;
        end else if (tag == tag_stat) begin
            dev = DEV_STAT;
        end
        return dev;
    endfunction

    function automatic logic [2:0] dev_strobe(input logic [2:0] dev);
        logic [2:0] strobe;
        case (dev)
            DEV_TIMER0: strobe = 3'b001;
            DEV_TIMER1: strobe = 3'b010;
            DEV_GPIO:   strobe = 3'b100;
            default:    strobe = 3'b000;
        endcase
        return strobe;
    endfunction

endpackage

// File: rtl/bridge_decode.sv
// Combinational decode of a latched word address into a device index and register select.
module bridge_decode
    import bridge_pkg::*;
#(
    parameter logic [31:0] DEV0_BASE = DEFAULT_DEV0_BASE,
    parameter logic [31:0] DEV1_BASE = DEFAULT_DEV1_BASE,
    parameter logic [31:0] DEV2_BASE = DEFAULT_DEV2_BASE,
    parameter logic [31:0] STAT_BASE = DEFAULT_STAT_BASE
) (
    input  logic [29:0] word_addr,
    output logic [2:0]  dev,
    output logic [1:0]  reg_sel
);

    assign dev = decode_tag(word_addr[29:2], DEV0_BASE[31:4], DEV1_BASE[31:4],
                            DEV2_BASE[31:4], STAT_BASE[31:4]);
    assign reg_sel = word_addr[1:0];

endmodule

// File: rtl/bus_bridge.sv
// Initiator end of the peripheral register bus: one-cycle device accesses, registered
// read data with a ready pulse, sticky decode-error flag and registered IRQ forwarding.
module bus_bridge
    import bridge_pkg::*;
#(
    parameter logic [31:0] DEV0_BASE = DEFAULT_DEV0_BASE,
    parameter logic [31:0] DEV1_BASE = DEFAULT_DEV1_BASE,
    parameter logic [31:0] DEV2_BASE = DEFAULT_DEV2_BASE,
    parameter logic [31:0] STAT_BASE = DEFAULT_STAT_BASE
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        PrReq,
    input  logic        PrWE,
    input  logic [31:0] PrAddr,
    input  logic [31:0] PrWD,
    output logic [31:0] PrRD,
    output logic        PrReady,
    output logic        PrErr,
    output logic [1:0]  DEV_ADDR,
    output logic [31:0] DEV_WD,
    output logic [2:0]  DEV_WE,
    input  logic [31:0] DEV_RD0,
    input  logic [31:0] DEV_RD1,
    input  logic [31:0] DEV_RD2,
    input  logic [2:0]  DEV_IRQ,
    output logic [5:0]  HWINT
);

    state_t      state;
    logic        lat_we;
    logic [29:0] lat_addr;
    logic [31:0] lat_wd;
    logic        err_flag;
    logic [2:0]  dev;
    logic [1:0]  reg_sel;
    logic [2:0]  req_dev;
    logic [31:0] read_word;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^PrAddr[1:0];

    bridge_decode #(
        .DEV0_BASE(DEV0_BASE),
        .DEV1_BASE(DEV1_BASE),
        .DEV2_BASE(DEV2_BASE),
        .STAT_BASE(STAT_BASE)
    ) u_decode (
        .word_addr(lat_addr),
        .dev      (dev),
        .reg_sel  (reg_sel)
    );

    // The write strobe is registered on acceptance, so it must decode the live request address.
    assign req_dev = decode_tag(PrAddr[31:4], DEV0_BASE[31:4], DEV1_BASE[31:4],
                                DEV2_BASE[31:4], STAT_BASE[31:4]);

    assign DEV_ADDR = reg_sel;
    assign DEV_WD   = lat_wd;

    always_comb begin
        read_word = 32'd0;
        case (dev)
            DEV_TIMER0: read_word = DEV_RD0;
            DEV_TIMER1: read_word = DEV_RD1;
            DEV_GPIO:   read_word = DEV_RD2;
            DEV_STAT: begin
                case (reg_sel)
                    2'd0:    read_word = {29'd0, DEV_IRQ};
                    2'd1:    read_word = {31'd0, err_flag};
                    default: read_word = 32'd0;
                endcase
            end
            default:    read_word = 32'd0;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state    <= IDLE;
            lat_we   <= 1'b0;
            lat_addr <= 30'd0;
            lat_wd   <= 32'd0;
            PrRD     <= 32'd0;
            PrReady  <= 1'b0;
            PrErr    <= 1'b0;
            DEV_WE   <= 3'b000;
            err_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    PrReady <= 1'b0;
                    PrErr   <= 1'b0;
                    if (PrReq) begin
                        lat_we   <= PrWE;
                        lat_addr <= PrAddr[31:2];
                        lat_wd   <= PrWD;
                        DEV_WE   <= PrWE ? dev_strobe(req_dev) : 3'b000;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    DEV_WE  <= 3'b000;
                    PrReady <= 1'b1;
                    PrErr   <= (dev == DEV_NONE);
                    PrRD    <= lat_we ? 32'd0 : read_word;
                    // A decode error outranks a clear landing on the same edge.
                    if (dev == DEV_NONE) begin
                        err_flag <= 1'b1;
                    end else if (lat_we && dev == DEV_STAT && reg_sel == 2'd1) begin
                        err_flag <= 1'b0;
                    end
                    state <= RESP;
                end
                RESP: begin
                    PrReady <= 1'b0;
                    PrErr   <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    DEV_WE  <= 3'b000;
                    PrReady <= 1'b0;
                    PrErr   <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            HWINT <= 6'd0;
        end else begin
            HWINT <= {3'b000, DEV_IRQ};
        end
    end

endmodule

// File: tb/tb_bus_bridge.sv
// Bench for bus_bridge: directed scenarios plus randomized accesses against a
// window-arithmetic reference model, with three simple register peripherals attached.
module tb_bus_bridge;

    logic        CLK_I;
    logic        RST_I;
    logic        PrReq;
    logic        PrWE;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic [31:0] PrRD;
    logic        PrReady;
    logic        PrErr;
    logic [1:0]  DEV_ADDR;
    logic [31:0] DEV_WD;
    logic [2:0]  DEV_WE;
    logic [31:0] DEV_RD0;
    logic [31:0] DEV_RD1;
    logic [31:0] DEV_RD2;
    logic [2:0]  DEV_IRQ;
    logic [5:0]  HWINT;

    int checks;
    int failures;

    logic [31:0] dev_regs [3][4];
    logic [31:0] ref_regs [3][4];
    logic        ref_err;
    logic [31:0] dev_cnt;
    logic        cnt_en;
    logic        dev_init;
    logic [31:0] seed;

    bus_bridge dut (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .PrReq   (PrReq),
        .PrWE    (PrWE),
        .PrAddr  (PrAddr),
        .PrWD    (PrWD),
        .PrRD    (PrRD),
        .PrReady (PrReady),
        .PrErr   (PrErr),
        .DEV_ADDR(DEV_ADDR),
        .DEV_WD  (DEV_WD),
        .DEV_WE  (DEV_WE),
        .DEV_RD0 (DEV_RD0),
        .DEV_RD1 (DEV_RD1),
        .DEV_RD2 (DEV_RD2),
        .DEV_IRQ (DEV_IRQ),
        .HWINT   (HWINT)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    // Peripherals: plain register files, device 0 word 2 optionally a free-running counter.
    always_comb begin
        DEV_RD0 = dev_regs[0][DEV_ADDR];
        if (cnt_en && DEV_ADDR == 2'd2) DEV_RD0 = dev_cnt;
        DEV_RD1 = dev_regs[1][DEV_ADDR];
        DEV_RD2 = dev_regs[2][DEV_ADDR];
    end

    always @(posedge CLK_I) begin
        if (dev_init) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 4; j++)
                    dev_regs[i][j] <= seed ^ 32'(i * 4 + j);
            dev_cnt <= 32'h0000_0100;
        end else begin
            for (int i = 0; i < 3; i++)
                if (DEV_WE[i]) dev_regs[i][DEV_ADDR] <= DEV_WD;
            if (cnt_en) dev_cnt <= dev_cnt + 32'd1;
        end
    end

    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        int unsigned off;
        if (addr < 32'h7F00 || addr >= 32'h7F40) return 32'd0;
        off = addr - 32'h7F00;
        if (off / 16 < 3) return ref_regs[off / 16][(off % 16) / 4];
        if ((off % 16) / 4 == 0) return {29'd0, DEV_IRQ};
        if ((off % 16) / 4 == 1) return {31'd0, ref_err};
        return 32'd0;
    endfunction

    function automatic void ref_apply(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int unsigned off;
        if (addr < 32'h7F00 || addr >= 32'h7F40) begin
            ref_err = 1'b1;
            return;
        end
        off = addr - 32'h7F00;
        if (we && off / 16 < 3) ref_regs[off / 16][(off % 16) / 4] = wd;
        else if (we && off / 16 == 3 && (off % 16) / 4 == 1) ref_err = 1'b0;
    endfunction

    // Drives one access from an idle bus and observes it until the ready pulse (bounded).
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rd, output logic err, output int lat,
                             output logic [2:0] we_mask, output int we_cycles,
                             output logic [1:0] we_addr, output logic [31:0] we_data,
                             output logic [31:0] cnt_pre);
        @(negedge CLK_I);
        PrReq = 1'b1; PrWE = we; PrAddr = addr; PrWD = wd;
        lat = 0; we_mask = 3'b000; we_cycles = 0; we_addr = 2'd0; we_data = 32'd0; cnt_pre = 32'd0;
        do begin
            @(negedge CLK_I);
            lat++;
            if (lat == 1) cnt_pre = dev_cnt;
            if (DEV_WE != 3'b000) begin
                we_mask = we_mask | DEV_WE; we_cycles++; we_addr = DEV_ADDR; we_data = DEV_WD;
            end
        end while (!PrReady && lat < 10);
        rd = PrRD; err = PrErr;
        PrReq = 1'b0; PrWE = 1'b0;
    endtask

    task automatic test_reset();
        seed = $urandom;
        RST_I = 1'b0; DEV_IRQ = 3'b101; dev_init = 1'b1;
        repeat (2) @(negedge CLK_I);
        dev_init = 1'b0;
        checks++; if ({PrReady, PrErr, DEV_WE} !== 5'd0) begin failures++; $display("[TB] FAIL reset_ctrl got=%b exp=00000", {PrReady, PrErr, DEV_WE}); end
        checks++; if (PrRD !== 32'd0) begin failures++; $display("[TB] FAIL reset_prrd got=%h exp=0", PrRD); end
        checks++; if ({DEV_ADDR, DEV_WD} !== 34'd0) begin failures++; $display("[TB] FAIL reset_dev_bus got=%h exp=0", {DEV_ADDR, DEV_WD}); end
        checks++; if (HWINT !== 6'd0) begin failures++; $display("[TB] FAIL reset_hwint got=%b exp=000000", HWINT); end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++)
                ref_regs[i][j] = dev_regs[i][j];
        ref_err = 1'b0; DEV_IRQ = 3'b000;
        RST_I = 1'b1;
        repeat (2) @(negedge CLK_I);
        checks++; if (PrReady !== 1'b0) begin failures++; $display("[TB] FAIL idle_no_ready got=%b exp=0", PrReady); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, wdat, cpre; logic err; int lat, wcyc; logic [2:0] wm; logic [1:0] wa;
        do_access(1'b1, 32'h7F00, 32'h0000_0009, rd, err, lat, wm, wcyc, wa, wdat, cpre);
        ref_apply(1'b1, 32'h7F00, 32'h0000_0009);
        checks++; if (wm !== 3'b001) begin failures++; $display("[TB] FAIL st0_we got=%b exp=001", wm); end
        checks++; if (wcyc !== 1) begin failures++; $display("[TB] FAIL st0_we_width got=%0d exp=1", wcyc); end
        checks++; if (wa !== 2'd0 || wdat !== 32'h9) begin failures++; $display("[TB] FAIL st0_bus got=%0d/%h exp=0/9", wa, wdat); end
        checks++; if (lat !== 2 || err !== 1'b0) begin failures++; $display("[TB] FAIL st0_ready got=%0d/%b exp=2/0", lat, err); end
        do_access(1'b0, 32'h7F00, 32'd0, rd, err, lat, wm, wcyc, wa, wdat, cpre);
        checks++; if (rd !== 32'h0000_0009) begin failures++; $display("[TB] FAIL ld0_data got=%h exp=00000009", rd); end
        checks++; if (lat !== 2 || wm !== 3'b000) begin failures++; $display("[TB] FAIL ld0_lat got=%0d/%b exp=2/000", lat, wm); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, wdat, cpre; logic err; int lat, wcyc; logic [2:0] wm; logic [1:0] wa;
        do_access(1'b1, 32'h7F40, 32'hDEAD_BEEF, rd, err, lat, wm, wcyc, wa, wdat, cpre);
        ref_apply(1'b1, 32'h7F40, 32'hDEAD_BEEF);
        checks++; if (wm !== 3'b000) begin failures++; $display("[TB] FAIL unm_we got=%b exp=000", wm); end
        checks++; if (err !== 1'b1 || lat !== 2) begin failures++; $display("[TB] FAIL unm_err got=%b/%0d exp=1/2", err, lat); end
        @(negedge CLK_I);
        checks++; if ({PrErr, PrReady} !== 2'b00) begin failures++; $display("[TB] FAIL unm_pulse got=%b exp=00", {PrErr, PrReady}); end
        do_access(1'b0, 32'h7F34, 32'd0, rd, err, lat, wm, wcyc, wa, wdat, cpre);
        checks++; if (rd !== 32'd1 || err !== 1'b0) begin failures++; $display("[TB] FAIL err_sticky got=%h/%b exp=1/0", rd, err); end
        do_access(1'b1, 32'h7F34, 32'h1234_5678, rd, err, lat, wm, wcyc, wa, wdat, cpre);
        ref_apply(1'b1, 32'h7F34, 32'h1234_5678);
        do_access(1'b0, 32'h7F34, 32'd0, rd, err, lat, wm, wcyc, wa, wdat, cpre);
        checks++; if (rd !== 32'd0) begin failures++; $display("[TB] FAIL err_clear got=%h exp=0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_ld, wd, ld_rd, we_val; int rcnt, first, second, wcnt, wt;
        exp_ld = ref_read(32'h7F14); wd = $urandom;
        rcnt = 0; first = 0; second = 0; wcnt = 0; wt = 0; ld_rd = 0; we_val = 0;
        @(negedge CLK_I);
        PrReq = 1'b1; PrWE = 1'b0; PrAddr = 32'h7F14; PrWD = 32'd0;
        for (int t = 1; t <= 8; t++) begin
            @(negedge CLK_I);
            if (DEV_WE != 3'b000) begin wcnt++; wt = t; we_val = {29'd0, DEV_WE}; end
            if (PrReady) begin
                rcnt++;
                if (rcnt == 1) begin first = t; ld_rd = PrRD; PrWE = 1'b1; PrAddr = 32'h7F24; PrWD = wd; end
                else begin second = t; PrReq = 1'b0; PrWE = 1'b0; end
            end
        end
        PrReq = 1'b0;
        ref_apply(1'b1, 32'h7F24, wd);
        checks++; if (rcnt !== 2 || first !== 2 || second !== 5) begin failures++; $display("[TB] FAIL b2b_ready got=%0d@%0d,%0d exp=2@2,5", rcnt, first, second); end
        checks++; if (ld_rd !== exp_ld) begin failures++; $display("[TB] FAIL b2b_load got=%h exp=%h", ld_rd, exp_ld); end
        checks++; if (wcnt !== 1 || wt !== 4 || we_val !== 32'd4) begin failures++; $display("[TB] FAIL b2b_we got=%0d@%0d/%h exp=1@4/4", wcnt, wt, we_val); end
        checks++; if (dev_regs[2][1] !== wd) begin failures++; $display("[TB] FAIL b2b_store got=%h exp=%h", dev_regs[2][1], wd); end
    endtask

    task automatic test_interrupt();
        logic [31:0] rd, wdat, cpre; logic err; int lat, wcyc; logic [2:0] wm; logic [1:0] wa;
        @(negedge CLK_I);
        DEV_IRQ = 3'b010;
        checks++; if (HWINT !== 6'd0) begin failures++; $display("[TB] FAIL irq_lag got=%b exp=000000", HWINT); end
        @(negedge CLK_I);
        checks++; if (HWINT !== 6'b000010) begin failures++; $display("[TB] FAIL irq_rise got=%b exp=000010", HWINT); end
        do_access(1'b0, 32'h7F30, 32'd0, rd, err, lat, wm, wcyc, wa, wdat, cpre);
        checks++; if (rd !== 32'd2) begin failures++; $display("[TB] FAIL irq_status got=%h exp=2", rd); end
        @(negedge CLK_I);
        DEV_IRQ = 3'b000;
        @(negedge CLK_I);
        checks++; if (HWINT !== 6'd0) begin failures++; $display("[TB] FAIL irq_fall got=%b exp=000000", HWINT); end
    endtask

    task automatic test_reset_during_access();
        logic [31:0] old, rd, wdat, cpre; logic err; int lat, wcyc; logic [2:0] wm; logic [1:0] wa;
        old = ref_regs[1][0];
        @(negedge CLK_I);
        PrReq = 1'b1; PrWE = 1'b1; PrAddr = 32'h7F10; PrWD = ~old;
        @(posedge CLK_I);
        #2;
        checks++; if (DEV_WE !== 3'b010) begin failures++; $display("[TB] FAIL rst_pre_we got=%b exp=010", DEV_WE); end
        RST_I = 1'b0;
        #1;
        checks++; if ({DEV_WE, PrReady} !== 4'd0) begin failures++; $display("[TB] FAIL rst_abort got=%b exp=0000", {DEV_WE, PrReady}); end
        PrReq = 1'b0; PrWE = 1'b0;
        repeat (2) @(negedge CLK_I);
        RST_I = 1'b1; ref_err = 1'b0;
        @(negedge CLK_I);
        checks++; if (dev_regs[1][0] !== old) begin failures++; $display("[TB] FAIL rst_no_write got=%h exp=%h", dev_regs[1][0], old); end
        do_access(1'b0, 32'h7F10, 32'd0, rd, err, lat, wm, wcyc, wa, wdat, cpre);
        checks++; if (lat !== 2 || rd !== old) begin failures++; $display("[TB] FAIL rst_recover got=%0d/%h exp=2/%h", lat, rd, old); end
    endtask

    task automatic test_counter();
        logic [31:0] rd, wdat, cpre; logic err; int lat, wcyc; logic [2:0] wm; logic [1:0] wa;
        @(negedge CLK_I);
        cnt_en = 1'b1;
        repeat (3) @(negedge CLK_I);
        do_access(1'b0, 32'h7F08, 32'd0, rd, err, lat, wm, wcyc, wa, wdat, cpre);
        cnt_en = 1'b0;
        checks++; if (rd !== cpre) begin failures++; $display("[TB] FAIL cnt_sample got=%h exp=%h", rd, cpre); end
    endtask

    task automatic test_random();
        logic [31:0] addr, wd, rd, wdat, cpre, exp_rd; logic err, we, exp_err; int lat, wcyc, kind, word;
        logic [2:0] wm, exp_we; logic [1:0] wa;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4); word = $urandom_range(0, 3);
            we = 1'($urandom_range(0, 1)); wd = $urandom;
            if (kind < 4) begin
                addr = 32'h7F00 + 32'(kind * 16 + word * 4) + 32'($urandom_range(0, 3));
            end else begin
                addr = $urandom;
                if (addr[31:6] == 26'h1FC) addr[31] = ~addr[31];
            end
            DEV_IRQ = 3'($urandom_range(0, 7));
            exp_rd = we ? 32'd0 : ref_read(addr);
            exp_err = (kind == 4);
            exp_we = (we && kind < 3) ? 3'(1 << kind) : 3'b000;
            do_access(we, addr, wd, rd, err, lat, wm, wcyc, wa, wdat, cpre);
            ref_apply(we, addr, wd);
            checks++; if (rd !== exp_rd || err !== exp_err || lat !== 2) begin failures++; $display("[TB] FAIL rnd_resp addr=%h we=%b got=%h/%b/%0d exp=%h/%b/2", addr, we, rd, err, lat, exp_rd, exp_err); end
            checks++; if (wm !== exp_we || (exp_we != 3'b000 && (wcyc !== 1 || wa !== 2'(word) || wdat !== wd))) begin failures++; $display("[TB] FAIL rnd_strobe addr=%h got=%b/%0d/%0d/%h exp=%b/1/%0d/%h", addr, wm, wcyc, wa, wdat, exp_we, word, wd); end
        end
        DEV_IRQ = 3'b000;
    endtask

    initial begin
        checks = 0; failures = 0;
        PrReq = 1'b0; PrWE = 1'b0; PrAddr = 32'd0; PrWD = 32'd0;
        DEV_IRQ = 3'b000; cnt_en = 1'b0; dev_init = 1'b0; RST_I = 1'b0; seed = 32'd0; ref_err = 1'b0;
        test_reset();
        test_store_load();
        test_unmapped();
        test_back_to_back();
        test_interrupt();
        test_reset_during_access();
        test_counter();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
